// File: rtl/aha_ahb_ram_scrub.sv
// aha_ahb_ram_scrub
//   AHB-Lite stage in front of the AHB SRAM slave. After reset (optional) or
//   on an INIT_START pulse it becomes the RAM-side master and writes PATTERN
//   to every 32-bit word. An upstream transfer arriving during the scrub is
//   held and replayed afterwards. Otherwise it is a zero-latency pass-through.
//
// Ports
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   INIT_START           single-cycle re-scrub request (honoured only in PASS)
//   S_*                  upstream AHB slave-side interface (from interconnect)
//   M_*                  downstream AHB interface towards the RAM
//   INIT_BUSY            high while a scrub, drain or replay is in progress
//   INIT_ERR             sticky error seen on a scrub write, cleared on scrub start
module aha_ahb_ram_scrub #(
  parameter int unsigned AW            = 16,
  parameter logic [31:0] PATTERN       = 32'h0000_0000,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        INIT_START,
  input  logic        S_HSEL,
  input  logic        S_HREADY,
  input  logic        S_HWRITE,
  input  logic [1:0]  S_HTRANS,
  input  logic [2:0]  S_HSIZE,
  input  logic [31:0] S_HADDR,
  input  logic [31:0] S_HWDATA,
  output logic        S_HREADYOUT,
  output logic [1:0]  S_HRESP,
  output logic [31:0] S_HRDATA,
  output logic        M_HSEL,
  output logic        M_HREADY,
  output logic        M_HWRITE,
  output logic [1:0]  M_HTRANS,
  output logic [2:0]  M_HSIZE,
  output logic [31:0] M_HADDR,
  output logic [31:0] M_HWDATA,
  input  logic        M_HREADYOUT,
  input  logic [1:0]  M_HRESP,
  input  logic [31:0] M_HRDATA,
  output logic        INIT_BUSY,
  output logic        INIT_ERR
);

  localparam int unsigned CW = AW - 2;

  typedef enum logic [2:0] {
    PASS,
    DRAIN,
    INIT,
    INIT_LAST,
    REPLAY
  } state_t;

  localparam state_t RESET_STATE = INIT_ON_RESET ? INIT : PASS;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          cap_vld;
  logic [31:0]   cap_addr;
  logic          cap_write;
  logic [2:0]    cap_size;
  logic [1:0]    cap_trans;
  logic          init_err;
  logic          start_pend;
  logic          dp_pend;     // a downstream data phase is outstanding
  logic          cap_fire;
  logic [31:0]   word_addr;

  assign word_addr = 32'(cnt) << 2;
  assign cap_fire  = (state != PASS) && S_HSEL && S_HREADY && S_HTRANS[1] && !cap_vld;

  assign INIT_BUSY = (state != PASS);
  assign INIT_ERR  = init_err;

  always_comb begin
    M_HSEL      = S_HSEL;
    M_HTRANS    = S_HTRANS;
    M_HSIZE     = S_HSIZE;
    M_HWRITE    = S_HWRITE;
    M_HADDR     = S_HADDR;
    M_HWDATA    = S_HWDATA;
    M_HREADY    = M_HREADYOUT;
    S_HREADYOUT = !cap_vld;
    S_HRESP     = 2'b00;
    S_HRDATA    = M_HRDATA;
    unique case (state)
      PASS: begin
        M_HREADY    = S_HREADY;
        S_HREADYOUT = M_HREADYOUT;
        S_HRESP     = M_HRESP;
      end
      DRAIN: begin
        M_HTRANS = 2'b00;
        if (dp_pend) begin
          S_HREADYOUT = M_HREADYOUT;
          S_HRESP     = M_HRESP;
        end
      end
      INIT: begin
        M_HSEL   = 1'b1;
        M_HTRANS = 2'b10;
        M_HWRITE = 1'b1;
        M_HSIZE  = 3'b010;
        M_HADDR  = word_addr;
        M_HWDATA = PATTERN;
      end
      INIT_LAST: begin
        M_HSEL   = 1'b1;
        M_HTRANS = 2'b00;
        M_HWRITE = 1'b1;
        M_HSIZE  = 3'b010;
        M_HADDR  = word_addr;
        M_HWDATA = PATTERN;
      end
      REPLAY: begin
        M_HSEL   = 1'b1;
        M_HTRANS = cap_trans & 2'b10;   // NONSEQ or SEQ both replay as NONSEQ
        M_HWRITE = cap_write;
        M_HSIZE  = cap_size;
        M_HADDR  = cap_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= RESET_STATE;
      cnt        <= '0;
      cap_vld    <= 1'b0;
      cap_addr   <= '0;
      cap_write  <= 1'b0;
      cap_size   <= '0;
      cap_trans  <= '0;
      init_err   <= 1'b0;
      start_pend <= 1'b0;
      dp_pend    <= 1'b0;
    end else begin
      if (M_HREADY)
        dp_pend <= M_HSEL & M_HTRANS[1];

      if (cap_fire) begin
        cap_vld   <= 1'b1;
        cap_addr  <= S_HADDR;
        cap_write <= S_HWRITE;
        cap_size  <= S_HSIZE;
        cap_trans <= S_HTRANS;
      end

      if ((state == INIT || state == INIT_LAST) && dp_pend && M_HRESP[0])
        init_err <= 1'b1;

      unique case (state)
        PASS: begin
          if (start_pend) begin
            start_pend <= 1'b0;
            state      <= DRAIN;
          end else if (INIT_START) begin
            start_pend <= 1'b1;
          end
        end
        DRAIN: begin
          if (!dp_pend || M_HREADYOUT) begin
            state    <= INIT;
            cnt      <= '0;
            init_err <= 1'b0;
          end
        end
        INIT: begin
          if (M_HREADYOUT) begin
            if (&cnt)
              state <= INIT_LAST;
            else
              cnt <= cnt + 1'b1;
          end
        end
        INIT_LAST: begin
          // A capture landing on the exit cycle must still be replayed.
          if (M_HREADYOUT)
            state <= (cap_vld || cap_fire) ? REPLAY : PASS;
        end
        REPLAY: begin
          cap_vld <= 1'b0;
          state   <= PASS;
        end
        default: state <= RESET_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_aha_ahb_ram_scrub.sv
// tb_aha_ahb_ram_scrub
//   Randomised bench for aha_ahb_ram_scrub (AW=8, PATTERN=DEADBEEF). A
//   behavioural AHB RAM with programmable wait states and error injection sits
//   on the M side; an array of expected word contents tracks what the RAM
//   must hold. A second instance with INIT_ON_RESET=0 checks pass-through.
module tb_aha_ahb_ram_scrub;

  localparam logic [31:0] PAT = 32'hDEADBEEF;
  localparam int LIM = 5000;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  // upstream master (dut0)
  logic        init_start = 1'b0;
  logic        s_hsel = 1'b0, s_hwrite = 1'b0;
  logic [1:0]  s_htrans = 2'b00;
  logic [2:0]  s_hsize = 3'b010;
  logic [31:0] s_haddr = '0, s_hwdata = '0;
  logic        s_hready, s_hreadyout;
  logic [1:0]  s_hresp;
  logic [31:0] s_hrdata;
  logic        m_hsel, m_hready, m_hwrite;
  logic [1:0]  m_htrans;
  logic [2:0]  m_hsize;
  logic [31:0] m_haddr, m_hwdata;
  logic        m_hreadyout;
  logic [1:0]  m_hresp;
  logic [31:0] m_hrdata;
  logic        init_busy, init_err;

  assign s_hready = s_hreadyout;   // single-slave interconnect

  aha_ahb_ram_scrub #(.AW(8), .PATTERN(PAT), .INIT_ON_RESET(1'b1)) dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .INIT_START(init_start),
    .S_HSEL(s_hsel), .S_HREADY(s_hready), .S_HWRITE(s_hwrite),
    .S_HTRANS(s_htrans), .S_HSIZE(s_hsize), .S_HADDR(s_haddr), .S_HWDATA(s_hwdata),
    .S_HREADYOUT(s_hreadyout), .S_HRESP(s_hresp), .S_HRDATA(s_hrdata),
    .M_HSEL(m_hsel), .M_HREADY(m_hready), .M_HWRITE(m_hwrite),
    .M_HTRANS(m_htrans), .M_HSIZE(m_hsize), .M_HADDR(m_haddr), .M_HWDATA(m_hwdata),
    .M_HREADYOUT(m_hreadyout), .M_HRESP(m_hresp), .M_HRDATA(m_hrdata),
    .INIT_BUSY(init_busy), .INIT_ERR(init_err)
  );

  // pass-through instance (no scrub on reset)
  logic        p_hsel = 1'b0, p_hready = 1'b1, p_hwrite = 1'b0, p_start = 1'b0;
  logic [1:0]  p_htrans = 2'b00;
  logic [2:0]  p_hsize = 3'b010;
  logic [31:0] p_haddr = '0, p_hwdata = '0;
  logic        p_mreadyout = 1'b1;
  logic [1:0]  p_mresp = 2'b00;
  logic [31:0] p_mrdata = '0;
  logic        d1_hreadyout, d1_mhsel, d1_mhready, d1_mhwrite, d1_busy, d1_err;
  logic [1:0]  d1_hresp, d1_mhtrans;
  logic [2:0]  d1_mhsize;
  logic [31:0] d1_hrdata, d1_mhaddr, d1_mhwdata;

  aha_ahb_ram_scrub #(.AW(8), .PATTERN(PAT), .INIT_ON_RESET(1'b0)) dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .INIT_START(p_start),
    .S_HSEL(p_hsel), .S_HREADY(p_hready), .S_HWRITE(p_hwrite),
    .S_HTRANS(p_htrans), .S_HSIZE(p_hsize), .S_HADDR(p_haddr), .S_HWDATA(p_hwdata),
    .S_HREADYOUT(d1_hreadyout), .S_HRESP(d1_hresp), .S_HRDATA(d1_hrdata),
    .M_HSEL(d1_mhsel), .M_HREADY(d1_mhready), .M_HWRITE(d1_mhwrite),
    .M_HTRANS(d1_mhtrans), .M_HSIZE(d1_mhsize), .M_HADDR(d1_mhaddr), .M_HWDATA(d1_mhwdata),
    .M_HREADYOUT(p_mreadyout), .M_HRESP(p_mresp), .M_HRDATA(p_mrdata),
    .INIT_BUSY(d1_busy), .INIT_ERR(d1_err)
  );

  // behavioural AHB RAM (64 words)
  logic [31:0] mem [64];
  logic        ram_dp = 1'b0, ram_wr = 1'b0;
  logic [31:0] ram_addr = '0;
  int          ram_wait = 0, ram_err = 0;
  int          wait_cfg = 0, err_word = -1;
  int          ram_rd_cnt = 0;
  logic [31:0] ram_last_rd = '0;
  logic [31:0] wlog_addr [$];
  logic [31:0] wlog_data [$];
  logic        ram_ready;

  assign ram_ready   = !ram_dp || (ram_err == 2) || (ram_err == 0 && ram_wait == 0);
  assign m_hreadyout = ram_ready;
  assign m_hresp     = (ram_err != 0) ? 2'b01 : 2'b00;
  assign m_hrdata    = mem[ram_addr[7:2]];

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ram_dp   <= 1'b0;
      ram_err  <= 0;
      ram_wait <= 0;
    end else begin
      if (ram_dp) begin
        if (ram_ready) begin
          ram_dp  <= 1'b0;
          ram_err <= 0;
          if (ram_wr) begin
            mem[ram_addr[7:2]] <= m_hwdata;
            wlog_addr.push_back(ram_addr);
            wlog_data.push_back(m_hwdata);
          end
        end else if (ram_err == 1) begin
          ram_err <= 2;
        end else begin
          ram_wait <= ram_wait - 1;
        end
      end
      if (m_hready && m_hsel && m_htrans[1]) begin
        ram_dp   <= 1'b1;
        ram_addr <= m_haddr;
        ram_wr   <= m_hwrite;
        if (m_hwrite && int'(m_haddr[7:2]) == err_word) begin
          ram_err  <= 1;
          ram_wait <= 0;
        end else begin
          ram_err  <= 0;
          ram_wait <= wait_cfg;
        end
        if (!m_hwrite) begin
          ram_rd_cnt  <= ram_rd_cnt + 1;
          ram_last_rd <= m_haddr;
        end
      end
    end
  end

  // expected RAM contents
  logic [31:0] ref_mem [64];

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic ref_scrub();
    for (int i = 0; i < 64; i++) ref_mem[i] = PAT;
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic [1:0] resp,
                      output int waits, output logic busy_done);
    int n;
    @(negedge HCLK);
    s_hsel = 1'b1; s_htrans = 2'b10; s_hwrite = wr; s_haddr = addr; s_hsize = 3'b010;
    #1;
    n = 0;
    while (!s_hready && n < LIM) begin @(negedge HCLK); #1; n++; end
    if (n >= LIM) chk("addr_timeout", n, 0);
    @(negedge HCLK);
    s_hsel = 1'b0; s_htrans = 2'b00; s_hwdata = wdata;
    #1;
    n = 0;
    while (!s_hready && n < LIM) begin @(negedge HCLK); #1; n++; end
    if (n >= LIM) chk("data_timeout", n, 0);
    rdata = s_hrdata; resp = s_hresp; waits = n; busy_done = init_busy;
  endtask

  task automatic pulse_start();
    @(negedge HCLK); init_start = 1'b1;
    @(negedge HCLK); init_start = 1'b0;
    repeat (2) @(negedge HCLK);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    #1;
    while (init_busy && n < LIM) begin @(negedge HCLK); #1; n++; end
    if (n >= LIM) chk("idle_timeout", n, 0);
  endtask

  task automatic check_scrub(input string tag, input int base);
    int bad;
    chk({tag, "_count"}, wlog_addr.size() - base, 64);
    bad = 0;
    for (int i = 0; i < 64 && base + i < wlog_addr.size(); i++)
      if (wlog_addr[base+i] !== 32'(i * 4) || wlog_data[base+i] !== PAT) bad++;
    chk({tag, "_order"}, bad, 0);
  endtask

  task automatic rand_ops(input int n);
    logic [31:0] rd, a, d;
    logic [1:0]  rs;
    int          w;
    logic        b, wr;
    for (int i = 0; i < n; i++) begin
      wait_cfg = $urandom_range(0, 2);
      wr = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 63)) << 2;
      d  = $urandom;
      xfer(wr, a, d, rd, rs, w, b);
      if (wr) ref_mem[a[7:2]] = d;
      else begin
        chk("rand_rd", rd, ref_mem[a[7:2]]);
        chk("rand_resp", 32'(rs), 0);
      end
    end
    wait_cfg = 0;
  endtask

  task automatic check_pass(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge HCLK);
      p_hsel = 1'($urandom); p_hready = 1'($urandom); p_hwrite = 1'($urandom);
      p_htrans = 2'($urandom); p_hsize = 3'($urandom);
      p_haddr = $urandom; p_hwdata = $urandom;
      p_mreadyout = 1'($urandom); p_mresp = 2'($urandom); p_mrdata = $urandom;
      #1;
      chk("pt_busy", 32'(d1_busy), 0);
      chk("pt_haddr", d1_mhaddr, p_haddr);
      chk("pt_hwdata", d1_mhwdata, p_hwdata);
      chk("pt_ctrl", {d1_mhsel, d1_mhwrite, d1_mhtrans, d1_mhsize, d1_mhready},
                     {p_hsel, p_hwrite, p_htrans, p_hsize, p_hready});
      chk("pt_rsp", {d1_hreadyout, d1_hresp}, {p_mreadyout, p_mresp});
      chk("pt_rdata", d1_hrdata, p_mrdata);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    int          w, n, base, rc;
    logic        b;

    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = 'x;
    end

    // reset values
    repeat (3) @(negedge HCLK);
    #1;
    chk("rst_busy", 32'(init_busy), 1);
    chk("rst_err", 32'(init_err), 0);
    chk("rst_ready", 32'(s_hreadyout), 1);
    chk("rst_resp", 32'(s_hresp), 0);
    chk("rst_haddr", m_haddr, 0);
    chk("rst_d1_busy", 32'(d1_busy), 0);

    // power-on scrub: 64 words + final data phase
    HRESETn = 1'b1;
    base = wlog_addr.size();
    #1;
    n = 0;
    while (init_busy && n < LIM) begin n++; @(negedge HCLK); #1; end
    chk("busy_cycles", n, 65);
    ref_scrub();
    check_scrub("por", base);
    chk("por_err", 32'(init_err), 0);

    check_pass(4);
    rand_ops(24);

    // read of 0x40 captured ~10 cycles into a scrub; extra INIT_START ignored
    base = wlog_addr.size();
    pulse_start();
    ref_scrub();
    repeat (4) @(negedge HCLK);
    init_start = 1'b1;
    @(negedge HCLK); init_start = 1'b0;
    repeat (4) @(negedge HCLK);
    xfer(1'b0, 32'h40, '0, rd, rs, w, b);
    chk("cap_rdata", rd, PAT);
    chk("cap_resp", 32'(rs), 0);
    chk("cap_busy_done", 32'(b), 0);
    chk("cap_long_wait", 32'(w > 40), 1);
    chk("replay_addr", ram_last_rd, 32'h40);
    repeat (10) @(negedge HCLK);
    #1;
    chk("ignored_start", 32'(init_busy), 0);
    check_scrub("cap", base);

    // write captured during scrub is replayed afterwards
    pulse_start();
    ref_scrub();
    repeat (17) @(negedge HCLK);
    xfer(1'b1, 32'h80, 32'h12345678, rd, rs, w, b);
    ref_mem[32] = 32'h12345678;
    chk("capw_busy_done", 32'(b), 0);
    xfer(1'b0, 32'h80, '0, rd, rs, w, b);
    chk("capw_rd80", rd, ref_mem[32]);
    xfer(1'b0, 32'h84, '0, rd, rs, w, b);
    chk("capw_rd84", rd, ref_mem[33]);

    // INIT_START during a write data phase stalled by 3 wait states
    wait_cfg = 3;
    base = wlog_addr.size();
    fork
      xfer(1'b1, 32'h24, 32'hA5A5_0001, rd, rs, w, b);
      begin
        @(negedge HCLK); @(negedge HCLK);
        init_start = 1'b1;
        @(negedge HCLK); init_start = 1'b0;
      end
    join
    ref_mem[9] = 32'hA5A5_0001;
    chk("drain_waits", w, 3);
    wait_idle();
    ref_scrub();
    wait_cfg = 0;
    chk("drain_count", wlog_addr.size() - base, 65);
    if (wlog_addr.size() > base + 1) begin
      chk("drain_first_addr", wlog_addr[base], 32'h24);
      chk("drain_first_data", wlog_data[base], 32'hA5A5_0001);
      chk("drain_scrub_addr0", wlog_addr[base+1], 0);
    end
    xfer(1'b0, 32'h24, '0, rd, rs, w, b);
    chk("drain_rd", rd, ref_mem[9]);

    rand_ops(12);

    // error response on word 5
    err_word = 5;
    base = wlog_addr.size();
    pulse_start();
    ref_scrub();
    wait_idle();
    err_word = -1;
    chk("err_set", 32'(init_err), 1);
    check_scrub("err", base);
    repeat (5) @(negedge HCLK);
    #1;
    chk("err_sticky", 32'(init_err), 1);
    pulse_start();
    #1;
    chk("err_clr", 32'(init_err), 0);
    wait_idle();
    chk("err_clr_done", 32'(init_err), 0);

    // reset at word 30 with a capture held
    pulse_start();
    s_hsel = 1'b1; s_htrans = 2'b10; s_hwrite = 1'b0; s_haddr = 32'h40;
    @(negedge HCLK);
    s_hsel = 1'b0; s_htrans = 2'b00;
    #1;
    chk("held_ready_low", 32'(s_hreadyout), 0);
    base = wlog_addr.size();
    n = 0;
    while (wlog_addr.size() - base < 30 && n < LIM) begin @(negedge HCLK); n++; end
    if (n >= LIM) chk("w30_timeout", n, 0);
    rc = ram_rd_cnt;
    HRESETn = 1'b0;
    #1;
    chk("mid_busy", 32'(init_busy), 1);
    chk("mid_ready", 32'(s_hreadyout), 1);
    chk("mid_resp", 32'(s_hresp), 0);
    chk("mid_haddr", m_haddr, 0);
    chk("mid_d1_busy", 32'(d1_busy), 0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    base = wlog_addr.size();
    wait_idle();
    check_scrub("rst", base);
    chk("no_replay", ram_rd_cnt, rc);
    check_pass(2);
    rand_ops(8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aha_ahb_ram_scrub.md
Name: aha_ahb_ram_scrub

Overview:
AHB-Lite bridge stage placed directly upstream of the 64K AHB SRAM slave, between the interconnect slave port and the RAM. After reset, or on request, it acts as the bus master on the RAM side and writes PATTERN to every 32-bit word, so the RAM never returns uninitialised data. An upstream transfer that arrives during the scrub is held and replayed once the scrub finishes. Otherwise the block is a zero-latency pass-through.

Parameters:
AW, 16, byte address width of the downstream RAM; word count WORDS = 2^(AW-2)
PATTERN, 32'h0000_0000, write data used for every scrub word
INIT_ON_RESET, 1, 1: scrub starts automatically after reset; 0: reset goes to PASS

Ports:
HCLK  in  1  clock
HRESETn  in  1  reset, asynchronous, active-low
INIT_START  in  1  single-cycle pulse that requests a re-scrub
S_HSEL, S_HREADY, S_HWRITE  in  1 each  upstream AHB slave-side controls
S_HTRANS  in  2  upstream transfer type
S_HSIZE  in  3  upstream transfer size
S_HADDR, S_HWDATA  in  32 each  upstream address and write data
S_HREADYOUT  out  1  upstream ready
S_HRESP  out  2  upstream response
S_HRDATA  out  32  upstream read data
M_HSEL, M_HREADY, M_HWRITE  out  1 each  downstream controls to the RAM
M_HTRANS  out  2  downstream transfer type
M_HSIZE  out  3  downstream transfer size
M_HADDR, M_HWDATA  out  32 each  downstream address and write data
M_HREADYOUT  in  1  RAM ready
M_HRESP  in  2  RAM response
M_HRDATA  in  32  RAM read data
INIT_BUSY  out  1  high whenever state != PASS
INIT_ERR  out  1  sticky; set by an error response on a scrub write; cleared on scrub start

Behaviour:
- States: PASS, DRAIN, INIT, INIT_LAST, REPLAY.
- Reset state is INIT if INIT_ON_RESET=1, else PASS.
- Reset values: word counter = 0, capture valid = 0, INIT_ERR = 0, start-pending = 0, S_HREADYOUT = 1, S_HRESP = 0.
- Ready handling:
  - In PASS, M_HREADY = S_HREADY.
  - In every other state, M_HREADY = M_HREADYOUT, because the block is the sole downstream master.
- PASS:
  - M_HSEL, M_HTRANS, M_HSIZE, M_HWRITE, M_HADDR and M_HWDATA equal the matching S_* signals combinationally.
  - S_HREADYOUT, S_HRESP and S_HRDATA equal M_HREADYOUT, M_HRESP and M_HRDATA.
  - No added latency.
- PASS to DRAIN:
  - Triggered by an INIT_START pulse; the request is latched in start-pending, so one pulse is enough.
  - INIT_START is ignored in any state other than PASS.
- DRAIN:
  - Any outstanding downstream data phase completes through the pass-through path.
  - New upstream address phases are not forwarded (M_HTRANS = IDLE); they are captured instead.
  - Moves to INIT in the first cycle with no outstanding downstream data phase, or on the cycle M_HREADYOUT = 1 ends it.
- INIT:
  - Entry clears the word counter and INIT_ERR.
  - Drives M_HSEL=1, M_HTRANS=NONSEQ, M_HWRITE=1, M_HSIZE=word (3'b010), M_HADDR = counter<<2.
  - M_HWDATA = PATTERN during the data phase of each previous word.
  - The counter advances only when M_HREADYOUT = 1.
  - When the address phase for word WORDS-1 is accepted, the state moves to INIT_LAST.
- INIT_LAST:
  - M_HTRANS = IDLE, M_HWDATA = PATTERN.
  - When M_HREADYOUT = 1: go to REPLAY if capture valid, else PASS.
- Error responses: M_HRESP[0] = 1 on any scrub data phase sets INIT_ERR. The scrub continues regardless.
- Capture, in every state except PASS:
  - Condition: S_HSEL & S_HREADY & S_HTRANS[1] with capture valid = 0.
  - Registers HADDR, HWRITE, HSIZE and HTRANS, and sets capture valid.
  - S_HREADYOUT = 1 while no capture is held, so IDLE/BUSY transfers see zero-wait OKAY.
  - S_HREADYOUT = 0 from the cycle after capture until the replayed data phase completes. This makes a second capture impossible.
  - S_HRESP = 0 during scrub.
- REPLAY:
  - Drives M_* address-phase signals from the capture registers for exactly one cycle with M_HSEL=1.
  - Clears capture valid, then moves to PASS.
  - The following data phase is plain pass-through: M_HWDATA = S_HWDATA (held by the master during the wait), S_HREADYOUT = M_HREADYOUT.
  - A replayed NONSEQ or SEQ is driven downstream as NONSEQ.
- Counter width is AW-2 bits. The last word is all-ones; the counter does not wrap during a scrub.
- Asynchronous reset mid-scrub: everything returns to reset values. If INIT_ON_RESET=1 the scrub restarts from word 0; a held capture is discarded.

Test Plan:
- AW=8, INIT_ON_RESET=1, PATTERN=32'hDEADBEEF:
  - After reset, INIT_BUSY=1 for 65 cycles.
  - Writes hit addresses 0x00..0xFC in order.
  - Any read returns 32'hDEADBEEF; INIT_BUSY then drops to 0.
- Upstream read of 0x40 issued at cycle 10 of the scrub:
  - S_HREADYOUT stays 0 until the scrub ends.
  - REPLAY drives M_HADDR=0x40; S_HRDATA = DEADBEEF with OKAY.
- Upstream write of 0x12345678 to 0x80 during the scrub:
  - The write is replayed after the scrub.
  - A subsequent read of 0x80 returns 0x12345678 and a read of 0x84 returns DEADBEEF.
- INIT_START while the upstream has a write data phase stalled by M_HREADYOUT=0 for 3 cycles:
  - The write completes first, then INIT begins at 0x00.
  - INIT_START pulses during the scrub are ignored.
- Force M_HRESP=2'b01 on the data phase of word 5: INIT_ERR=1 at the end, the scrub completes all 64 words, and INIT_ERR clears on the next INIT_START.
- Assert HRESETn low at word 30:
  - Outputs return to reset values and the capture is dropped.
  - The scrub restarts from 0x00.
  - With INIT_ON_RESET=0 the block instead passes through immediately with zero latency.
